// File: rtl/cpu_clk_sched_pkg.sv
// Shared encodings for the CPU clock scheduler: debug-host command opcodes and FSM states.
package cpu_clk_sched_pkg;

   typedef enum logic [1:0] {
      OP_HALT   = 2'd0,
      OP_RUN    = 2'd1,
      OP_STEP   = 2'd2,
      OP_SETDIV = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_e;

endpackage

// File: rtl/cpu_clk_sched_tick_gen.sv
// Divide counter for the CPU tick: holds cnt, div and a deferred divide value that is
// only swapped in on a wrap so a running core never sees a truncated period.
module clk_tick_gen
   import cpu_clk_sched_pkg::*;
#(
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned DIV_INIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             active,
   input  logic             active_nxt,
   input  logic             set_en,
   input  logic [DIV_W-1:0] set_val,
   output logic             wrap,
   output logic             div_busy
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] pend;
   logic             pend_v;

   assign wrap     = active && (cnt == div);
   assign div_busy = pend_v;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         div    <= DIV_W'(DIV_INIT);
         pend   <= '0;
         pend_v <= 1'b0;
      end else begin
         // cnt is pinned to 0 in HALT, so leaving HALT always starts a fresh period
         if (!active || !active_nxt || wrap)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;

         if (set_en && !active) begin
            div <= set_val;
         end else if (set_en) begin
            pend   <= set_val;
            pend_v <= 1'b1;
         end else if (pend_v && (wrap || !active)) begin
            // !active covers a SETDIV taken on the edge that finished a STEP burst
            div    <= pend;
            pend_v <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cpu_clk_sched.sv
// Run/halt/step scheduler for the CPU divided clock, driven by the debug host over a
// valid/ready command port.
module cpu_clk_sched
   import cpu_clk_sched_pkg::*;
#(
   parameter int unsigned DIV_W     = 8,
   parameter int unsigned DIV_INIT  = 1,
   parameter bit          START_RUN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [DIV_W-1:0] cmd_arg,
   output logic             cpu_ce,
   output logic             dclk_out,
   output logic             halted,
   output logic [31:0]      tick_cnt
);

   localparam state_e RST_ST = START_RUN ? ST_RUN : ST_HALT;

   state_e           state, state_nxt;
   logic [DIV_W-1:0] step_left, step_nxt;
   logic             accept;
   logic             set_en;
   logic             wrap;
   logic             div_busy;
   cmd_op_e          op;

   assign op        = cmd_op_e'(cmd_op);
   assign cmd_ready = !div_busy;
   assign accept    = cmd_valid && cmd_ready;

   clk_tick_gen #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT)
   ) u_tick (
      .clk        (clk),
      .rst        (rst),
      .active     (state != ST_HALT),
      .active_nxt (state_nxt != ST_HALT),
      .set_en     (set_en),
      .set_val    (cmd_arg),
      .wrap       (wrap),
      .div_busy   (div_busy)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RST_ST;
         step_left <= '0;
      end else begin
         state     <= state_nxt;
         step_left <= step_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      step_nxt  = step_left;
      set_en    = 1'b0;

      if (state == ST_STEP && wrap) begin
         if (step_left <= DIV_W'(1)) begin
            step_nxt  = '0;
            state_nxt = ST_HALT;
         end else begin
            step_nxt = step_left - 1'b1;
         end
      end

      // An accepted command overrides the step bookkeeping of the same edge
      if (accept) begin
         case (op)
            OP_HALT: begin
               state_nxt = ST_HALT;
               step_nxt  = '0;
            end
            OP_RUN: begin
               state_nxt = ST_RUN;
               step_nxt  = '0;
            end
            OP_STEP: begin
               state_nxt = ST_STEP;
               step_nxt  = (cmd_arg == '0) ? DIV_W'(1) : cmd_arg;
            end
            default: set_en = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_ce   <= 1'b0;
         dclk_out <= 1'b1;
         halted   <= !START_RUN;
         tick_cnt <= '0;
      end else begin
         cpu_ce <= wrap;
         halted <= (state_nxt == ST_HALT);
         if (wrap) begin
            dclk_out <= ~dclk_out;
            tick_cnt <= tick_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Directed bench for cpu_clk_sched: run/halt/step/setdiv sequences with hand-derived
// per-cycle cpu_ce patterns.
module tb_cpu_clk_sched;
   import cpu_clk_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_arg;
   logic        cpu_ce;
   logic        dclk_out;
   logic        halted;
   logic [31:0] tick_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] ce_pat, rdy_pat, hlt_pat;

   cpu_clk_sched #(
      .DIV_W     (8),
      .DIV_INIT  (1),
      .START_RUN (1'b0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .cpu_ce    (cpu_ce),
      .dclk_out  (dclk_out),
      .halted    (halted),
      .tick_cnt  (tick_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle command; accepted on the next edge (caller ensures cmd_ready)
   task automatic send(input logic [1:0] op, input logic [7:0] arg);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      tick();
      cmd_valid = 1'b0;
      cmd_arg   = '0;
   endtask

   // Bit i = value after the (i+1)-th edge from now
   task automatic record(input int unsigned n, output logic [31:0] ce,
                         output logic [31:0] rdy, output logic [31:0] hlt);
      ce  = '0;
      rdy = '0;
      hlt = '0;
      for (int unsigned i = 0; i < n; i++) begin
         tick();
         ce[i]  = cpu_ce;
         rdy[i] = cmd_ready;
         hlt[i] = halted;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_arg   = '0;
      tick();
      tick();
      rst = 1'b0;

      // reset state, idle in HALT
      chk("rst_halted", 32'(halted), 32'd1);
      chk("rst_dclk", 32'(dclk_out), 32'd1);
      chk("rst_tick", tick_cnt, 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      record(20, ce_pat, rdy_pat, hlt_pat);
      chk("halt_no_ce", ce_pat, 32'h0);
      chk("halt_hold", hlt_pat, 32'h000F_FFFF);

      // RUN div=1: pulses every other cycle from T+2
      send(OP_RUN, 8'd0);
      chk("run_halted", 32'(halted), 32'd0);
      record(10, ce_pat, rdy_pat, hlt_pat);
      chk("run_div1_ce", ce_pat, 32'h2AA);
      chk("run_tick5", tick_cnt, 32'd5);
      chk("run_dclk", 32'(dclk_out), 32'd0);
      send(OP_HALT, 8'd0);
      record(10, ce_pat, rdy_pat, hlt_pat);
      chk("halt_after_run", ce_pat, 32'h0);
      chk("halt_tick", tick_cnt, 32'd5);

      // STEP 3 with div=2, then STEP 0
      send(OP_SETDIV, 8'd2);
      chk("setdiv_halt_ready", 32'(cmd_ready), 32'd1);
      send(OP_STEP, 8'd3);
      record(12, ce_pat, rdy_pat, hlt_pat);
      chk("step3_ce", ce_pat, 32'h124);
      chk("step3_halted", hlt_pat, 32'hF00);
      chk("step3_tick", tick_cnt, 32'd8);
      send(OP_STEP, 8'd0);
      record(9, ce_pat, rdy_pat, hlt_pat);
      chk("step0_ce", ce_pat, 32'h004);
      chk("step0_tick", tick_cnt, 32'd9);

      // SETDIV 4 while running at div=1
      send(OP_SETDIV, 8'd1);
      send(OP_RUN, 8'd0);
      tick();
      tick();
      send(OP_SETDIV, 8'd4);
      chk("setdiv_run_busy", 32'(cmd_ready), 32'd0);
      record(11, ce_pat, rdy_pat, hlt_pat);
      chk("setdiv_run_ce", ce_pat, 32'h421);
      chk("setdiv_run_ready", rdy_pat, 32'h7FF);
      chk("setdiv_run_tick", tick_cnt, 32'd13);
      send(OP_HALT, 8'd0);

      // div=0 gives a continuous enable; HALT on a wrap edge lets that pulse finish
      send(OP_SETDIV, 8'd0);
      send(OP_RUN, 8'd0);
      record(8, ce_pat, rdy_pat, hlt_pat);
      chk("div0_ce", ce_pat, 32'hFF);
      chk("div0_tick", tick_cnt, 32'd21);
      send(OP_HALT, 8'd0);
      chk("halt_finishes_pulse", 32'(cpu_ce), 32'd1);
      chk("halt_finishes_tick", tick_cnt, 32'd22);
      record(5, ce_pat, rdy_pat, hlt_pat);
      chk("halt_div0_ce", ce_pat, 32'h0);

      // HALT interrupting STEP 10 after 4 pulses
      send(OP_SETDIV, 8'd1);
      send(OP_STEP, 8'd10);
      record(8, ce_pat, rdy_pat, hlt_pat);
      chk("step10_ce", ce_pat, 32'hAA);
      send(OP_HALT, 8'd0);
      record(10, ce_pat, rdy_pat, hlt_pat);
      chk("step_halt_ce", ce_pat, 32'h0);
      chk("step_halt_left", 32'(dut.step_left), 32'd0);
      chk("step_halt_tick", tick_cnt, 32'd26);
      chk("step_halt_flag", 32'(halted), 32'd1);
      chk("dclk_parity", 32'(dclk_out), 32'd1);

      // reset mid-RUN with SETDIV 7 pending
      send(OP_RUN, 8'd0);
      tick();
      tick();
      send(OP_SETDIV, 8'd7);
      chk("pend_busy", 32'(cmd_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_ce", 32'(cpu_ce), 32'd0);
      chk("mid_rst_dclk", 32'(dclk_out), 32'd1);
      chk("mid_rst_halted", 32'(halted), 32'd1);
      chk("mid_rst_tick", tick_cnt, 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      send(OP_RUN, 8'd0);
      record(4, ce_pat, rdy_pat, hlt_pat);
      chk("mid_rst_div_init", ce_pat, 32'hA);
      chk("mid_rst_tick2", tick_cnt, 32'd2);
      send(OP_HALT, 8'd0);

      // tick_cnt wrap
      force dut.tick_cnt = 32'hFFFF_FFFF;
      tick();
      release dut.tick_cnt;
      tick();
      chk("preload_tick", tick_cnt, 32'hFFFF_FFFF);
      send(OP_RUN, 8'd0);
      tick();
      tick();
      chk("wrap_pulse", 32'(cpu_ce), 32'd1);
      chk("wrap_tick", tick_cnt, 32'd0);
      send(OP_HALT, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
